// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl
// Sequences core memory transactions onto an 8-bit, 4-phase handshaked
// external bus.
//
// Core side: a one-cycle xfer_start latches xfer_we, xfer_addr, xfer_wdata
// and xfer_byte_sel. The access is split into 1/2/4 little-endian byte beats.
// Completion is flagged by a one-cycle transfer_ok pulse. xfer_err pulses
// together with transfer_ok when a beat timed out. xfer_busy is high in
// every state except IDLE. xfer_rdata carries the assembled and extended
// read data, and holds its value until the next completion.
//
// External side: ext_req/ext_wr/ext_addr/ext_wdata go out and
// ext_ack/ext_rdata come back.
// Handshake, one beat:
//   1. ext_req rises with address, write flag and data stable.
//   2. The device raises ext_ack. ext_rdata is valid while ext_ack is high.
//   3. ext_req falls.
//   4. The device drops ext_ack, which ends the beat.
// A stale high ext_ack at the start of a request is waited out with
// ext_req low (WAIT_REL).
// All outputs are registered. Reset is asynchronous and active-low.
module ext_bus_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int EXTADDR_WIDTH  = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     xfer_start,
  input  logic                     xfer_we,
  input  logic [ADDR_WIDTH-1:0]    xfer_addr,
  input  logic [DATA_WIDTH-1:0]    xfer_wdata,
  input  logic [2:0]               xfer_byte_sel,
  output logic                     xfer_busy,
  output logic                     transfer_ok,
  output logic                     xfer_err,
  output logic [DATA_WIDTH-1:0]    xfer_rdata,
  output logic                     ext_req,
  output logic                     ext_wr,
  output logic [EXTADDR_WIDTH-1:0] ext_addr,
  output logic [7:0]               ext_wdata,
  input  logic [7:0]               ext_rdata,
  input  logic                     ext_ack
);

  typedef enum logic [2:0] {IDLE, WAIT_REL, REQ, RELEASE, DONE} state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t                   state_q, state_d;
  logic                     we_q, we_d;
  logic [EXTADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [2:0]               sel_q, sel_d;
  logic [1:0]               beat_q, beat_d;
  logic [DATA_WIDTH-1:0]    asm_q, asm_d;
  logic                     err_q, err_d;
  logic [7:0]               tmo_q, tmo_d;

  logic                     req_d, wr_d, busy_d, ok_d, xerr_d;
  logic [EXTADDR_WIDTH-1:0] ext_addr_d;
  logic [7:0]               ext_wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_d, ext_val;
  logic [1:0]               last_beat;
  logic                     timeout_hit;

  // Only the low EXTADDR_WIDTH address bits reach the external bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^xfer_addr[ADDR_WIDTH-1:EXTADDR_WIDTH];

  // Beat index of the final byte: 0 for byte, 1 for half, 3 for word/11.
  assign last_beat   = sel_q[1] ? 2'd3 : (sel_q[0] ? 2'd1 : 2'd0);
  assign timeout_hit = (tmo_q + 8'd1) == TMO_LIMIT;

  // Next-state and command/assembly registers.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (xfer_start) begin
          we_d    = xfer_we;
          addr_d  = xfer_addr[EXTADDR_WIDTH-1:0];
          wdata_d = xfer_wdata;
          sel_d   = xfer_byte_sel;
          beat_d  = 2'd0;
          asm_d   = '0;
          err_d   = 1'b0;
          state_d = ext_ack ? WAIT_REL : REQ;
        end
      end
      WAIT_REL: begin
        if (!ext_ack) begin
          state_d = REQ;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      REQ: begin
        if (ext_ack) begin
          if (!we_q) asm_d[{beat_q, 3'b000} +: 8] = ext_rdata;
          state_d = RELEASE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      RELEASE: begin
        if (!ext_ack) begin
          if (beat_q == last_beat) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = REQ;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sign/zero extension of the assembled bytes for the completing read.
  always_comb begin
    ext_val = asm_d;
    unique case (sel_d[1:0])
      2'b00: ext_val = {{(DATA_WIDTH-8){asm_d[7] & ~sel_d[2]}}, asm_d[7:0]};
      2'b01: ext_val = {{(DATA_WIDTH-16){asm_d[15] & ~sel_d[2]}}, asm_d[15:0]};
      default: ext_val = asm_d;
    endcase
  end

  // Registered outputs are computed from the next state so they change on
  // the same edge as the state register.
  always_comb begin
    tmo_d = '0;
    if (state_d == state_q &&
        (state_q == WAIT_REL || state_q == REQ || state_q == RELEASE))
      tmo_d = tmo_q + 8'd1;

    req_d       = (state_d == REQ);
    wr_d        = 1'b0;
    ext_addr_d  = ext_addr;
    ext_wdata_d = ext_wdata;
    if (state_d == REQ) begin
      wr_d        = we_d;
      ext_addr_d  = addr_d + EXTADDR_WIDTH'(beat_d);
      ext_wdata_d = wdata_d[{beat_d, 3'b000} +: 8];
    end

    busy_d  = (state_d != IDLE);
    ok_d    = (state_d == DONE);
    xerr_d  = (state_d == DONE) && err_d;
    rdata_d = xfer_rdata;
    if (state_d == DONE) begin
      if (err_d)      rdata_d = '1;
      else if (!we_d) rdata_d = ext_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      beat_q      <= '0;
      asm_q       <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      ext_req     <= 1'b0;
      ext_wr      <= 1'b0;
      ext_addr    <= '0;
      ext_wdata   <= '0;
      xfer_busy   <= 1'b0;
      transfer_ok <= 1'b0;
      xfer_err    <= 1'b0;
      xfer_rdata  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      beat_q      <= beat_d;
      asm_q       <= asm_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      ext_req     <= req_d;
      ext_wr      <= wr_d;
      ext_addr    <= ext_addr_d;
      ext_wdata   <= ext_wdata_d;
      xfer_busy   <= busy_d;
      transfer_ok <= ok_d;
      xfer_err    <= xerr_d;
      xfer_rdata  <= rdata_d;
    end
  end

endmodule
